// File: rtl/pipe_pkg.sv
// Shared types for the elastic pipeline stage: occupancy states and the
// flush/stall priority encoding used by every stage instance.
package pipe_pkg;

    localparam int OCC_W = 2;

    typedef enum logic [OCC_W-1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_e;

    typedef enum logic [1:0] {
        CTRL_NORMAL = 2'd0,
        CTRL_STALL  = 2'd1,
        CTRL_FLUSH  = 2'd2
    } pipe_ctrl_e;

    // Flush dominates stall, stall dominates normal operation.
    function automatic pipe_ctrl_e pipe_ctrl_decode(input logic flush, input logic stall);
        pipe_ctrl_e ctrl;
        ctrl = CTRL_NORMAL;
        if (flush) begin
            ctrl = CTRL_FLUSH;
        end else if (stall) begin
            ctrl = CTRL_STALL;
        end
        return ctrl;
    endfunction

endpackage

// File: rtl/pipe_data_reg.sv
// WIDTH-bit payload flop bank: async reset to 0, synchronous clear beats load enable.
module pipe_data_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipeline stage with flush and stall. Defining
// PIPE_STAGE_SKID_EN selects the two-entry skid build with a registered in_ready.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int CLEAR_ON_FLUSH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             stall,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] occupancy
);

    pipe_ctrl_e       ctrl;
    logic             in_fire;
    logic             out_fire;
    logic             main_valid;
    logic             main_load;
    logic             data_clr;
    logic [WIDTH-1:0] main_d;

    assign ctrl      = pipe_ctrl_decode(flush, stall);
    assign out_valid = main_valid & ~stall;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign data_clr  = (ctrl == CTRL_FLUSH) && (CLEAR_ON_FLUSH != 0);

`ifdef PIPE_STAGE_SKID_EN

    pipe_state_e      state;
    pipe_state_e      next_state;
    logic             ready_q;
    logic             skid_load;
    logic             main_from_skid;
    logic [WIDTH-1:0] skid_q;

    // ready_q mirrors "not TWO" one cycle ahead so in_ready never sees out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= EMPTY;
            ready_q <= 1'b1;
        end else begin
            state   <= next_state;
            ready_q <= (next_state != TWO);
        end
    end

    always_comb begin
        next_state     = state;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        case (ctrl)
            CTRL_FLUSH: begin
                next_state = EMPTY;
            end
            CTRL_NORMAL: begin
                case (state)
                    EMPTY: begin
                        if (in_fire) begin
                            main_load  = 1'b1;
                            next_state = ONE;
                        end
                    end
                    ONE: begin
                        if (in_fire && out_fire) begin
                            main_load = 1'b1;
                        end else if (in_fire) begin
                            skid_load  = 1'b1;
                            next_state = TWO;
                        end else if (out_fire) begin
                            next_state = EMPTY;
                        end
                    end
                    TWO: begin
                        if (out_fire) begin
                            main_load      = 1'b1;
                            main_from_skid = 1'b1;
                            next_state     = ONE;
                        end
                    end
                    default: begin
                        next_state = EMPTY;
                    end
                endcase
            end
            default: begin
                next_state = state;
            end
        endcase
    end

    assign in_ready   = ready_q & (ctrl == CTRL_NORMAL);
    assign main_valid = (state != EMPTY);
    assign occupancy  = state;
    assign main_d     = main_from_skid ? skid_q : in_data;

    pipe_data_reg #(
        .WIDTH(WIDTH)
    ) u_skid_reg (
        .clk(clk),
        .rst(rst),
        .en (skid_load),
        .clr(data_clr),
        .d  (in_data),
        .q  (skid_q)
    );

`else

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid <= 1'b0;
        end else begin
            case (ctrl)
                CTRL_FLUSH: begin
                    main_valid <= 1'b0;
                end
                CTRL_NORMAL: begin
                    if (in_fire) begin
                        main_valid <= 1'b1;
                    end else if (out_fire) begin
                        main_valid <= 1'b0;
                    end
                end
                default: begin
                    main_valid <= main_valid;
                end
            endcase
        end
    end

    // Combinational ready: a full stage accepts in the same cycle it drains.
    assign in_ready  = (ctrl == CTRL_NORMAL) & (~main_valid | out_ready);
    assign main_load = in_fire;
    assign main_d    = in_data;
    assign occupancy = main_valid ? ONE : EMPTY;

`endif

    pipe_data_reg #(
        .WIDTH(WIDTH)
    ) u_main_reg (
        .clk(clk),
        .rst(rst),
        .en (main_load),
        .clr(data_clr),
        .d  (main_d),
        .q  (out_data)
    );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic; two instances differ only in CLEAR_ON_FLUSH.
module tb_pipe_stage_elastic;

`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif
    localparam logic [31:0] MAX_OCC = SKID ? 32'd2 : 32'd1;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        stall;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;

    logic        in_ready_c, out_valid_c;
    logic [31:0] out_data_c;
    logic [1:0]  occ_c;
    logic        in_ready_h, out_valid_h;
    logic [31:0] out_data_h;
    logic [1:0]  occ_h;

    int vectors = 0;
    int misses  = 0;

    pipe_stage_elastic #(.WIDTH(32), .CLEAR_ON_FLUSH(1)) dut_clr (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_ready(in_ready_c), .in_data(in_data),
        .out_valid(out_valid_c), .out_ready(out_ready), .out_data(out_data_c),
        .occupancy(occ_c)
    );

    pipe_stage_elastic #(.WIDTH(32), .CLEAR_ON_FLUSH(0)) dut_hold (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_ready(in_ready_h), .in_data(in_data),
        .out_valid(out_valid_h), .out_ready(out_ready), .out_data(out_data_h),
        .occupancy(occ_h)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: run exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic f, input logic s, input logic iv,
                                 input logic [31:0] d, input logic ordy);
        flush     = f;
        stall     = s;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            misses++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(0, 0, 0, 32'h0, 0);
        #1;
        checkOutput("rst_out_valid", {31'b0, out_valid_c}, 32'd0);
        checkOutput("rst_occ", {30'b0, occ_c}, 32'd0);
        checkOutput("rst_out_data", out_data_c, 32'd0);
        checkOutput("rst_in_ready", {31'b0, in_ready_c}, 32'd1);
        #8;
        rst = 1'b0;
        tick();

        // Streaming 0x1..0x10 with continuous valid/ready
        applyStimulus(0, 0, 1, 32'h1, 1);
        for (int i = 1; i <= 16; i++) begin
            tick();
            checkOutput("stream_valid", {31'b0, out_valid_c}, 32'd1);
            checkOutput("stream_data", out_data_c, 32'(i));
            applyStimulus(0, 0, (i < 16), 32'(i + 1), 1);
        end
        tick();
        checkOutput("stream_drain_valid", {31'b0, out_valid_c}, 32'd0);
        checkOutput("stream_drain_occ", {30'b0, occ_c}, 32'd0);

        // Backpressure: 0xA then 0xB with out_ready low
        applyStimulus(0, 0, 1, 32'hA, 0);
        checkOutput("bp_ready_empty", {31'b0, in_ready_c}, 32'd1);
        tick();
        checkOutput("bp_a_valid", {31'b0, out_valid_c}, 32'd1);
        checkOutput("bp_a_data", out_data_c, 32'hA);
        applyStimulus(0, 0, 1, 32'hB, 0);
        checkOutput("bp_ready_one", {31'b0, in_ready_c}, {31'b0, SKID});
        tick();
        checkOutput("bp_full_occ", {30'b0, occ_c}, MAX_OCC);
        checkOutput("bp_full_ready", {31'b0, in_ready_c}, 32'd0);
        checkOutput("bp_full_data", out_data_c, 32'hA);
        applyStimulus(0, 0, !SKID, 32'hB, 1);
        checkOutput("bp_drain_a_valid", {31'b0, out_valid_c}, 32'd1);
        checkOutput("bp_drain_a_data", out_data_c, 32'hA);
        tick();
        applyStimulus(0, 0, 0, 32'h0, 1);
        checkOutput("bp_drain_b_valid", {31'b0, out_valid_c}, 32'd1);
        checkOutput("bp_drain_b_data", out_data_c, 32'hB);
        checkOutput("bp_drain_b_occ", {30'b0, occ_c}, 32'd1);
        tick();
        checkOutput("bp_empty_valid", {31'b0, out_valid_c}, 32'd0);
        checkOutput("bp_empty_occ", {30'b0, occ_c}, 32'd0);

        // Flush a full stage
        applyStimulus(0, 0, 1, 32'hC, 0);
        tick();
        applyStimulus(0, 0, 1, 32'hD, 0);
        tick();
        checkOutput("flush_pre_occ", {30'b0, occ_c}, MAX_OCC);
        applyStimulus(1, 0, !SKID, 32'hD, 0);
        checkOutput("flush_in_ready", {31'b0, in_ready_c}, 32'd0);
        tick();
        applyStimulus(0, 0, 0, 32'h0, 0);
        checkOutput("flush_clr_valid", {31'b0, out_valid_c}, 32'd0);
        checkOutput("flush_clr_occ", {30'b0, occ_c}, 32'd0);
        checkOutput("flush_clr_data", out_data_c, 32'd0);
        checkOutput("flush_hold_valid", {31'b0, out_valid_h}, 32'd0);
        checkOutput("flush_hold_occ", {30'b0, occ_h}, 32'd0);
        checkOutput("flush_hold_data", out_data_h, 32'hC);
        checkOutput("flush_post_ready", {31'b0, in_ready_c}, 32'd1);

        // Stall for 3 cycles while holding 0x55
        applyStimulus(0, 0, 1, 32'h55, 0);
        tick();
        applyStimulus(0, 1, 1, 32'h66, 1);
        for (int i = 0; i < 3; i++) begin
            checkOutput("stall_out_valid", {31'b0, out_valid_c}, 32'd0);
            checkOutput("stall_in_ready", {31'b0, in_ready_c}, 32'd0);
            tick();
            checkOutput("stall_occ", {30'b0, occ_c}, 32'd1);
            checkOutput("stall_data", out_data_c, 32'h55);
        end
        applyStimulus(0, 0, 0, 32'h0, 1);
        checkOutput("stall_rel_valid", {31'b0, out_valid_c}, 32'd1);
        checkOutput("stall_rel_data", out_data_c, 32'h55);
        tick();
        checkOutput("stall_once_valid", {31'b0, out_valid_c}, 32'd0);
        checkOutput("stall_once_occ", {30'b0, occ_c}, 32'd0);

        // Flush and stall together while 0x77 is offered
        applyStimulus(0, 0, 1, 32'h33, 0);
        tick();
        applyStimulus(1, 1, 1, 32'h77, 1);
        checkOutput("fs_in_ready", {31'b0, in_ready_c}, 32'd0);
        checkOutput("fs_out_valid", {31'b0, out_valid_c}, 32'd0);
        tick();
        applyStimulus(0, 0, 0, 32'h0, 0);
        checkOutput("fs_occ", {30'b0, occ_c}, 32'd0);
        checkOutput("fs_valid", {31'b0, out_valid_c}, 32'd0);
        checkOutput("fs_clr_data", out_data_c, 32'd0);
        checkOutput("fs_hold_occ", {30'b0, occ_h}, 32'd0);
        checkOutput("fs_hold_data", out_data_h, 32'h33);

        // Asynchronous reset with the stage full
        applyStimulus(0, 0, 1, 32'hE, 0);
        tick();
        applyStimulus(0, 0, 1, 32'hF, 0);
        tick();
        checkOutput("arst_pre_occ", {30'b0, occ_c}, MAX_OCC);
        rst = 1'b1;
        #1;
        checkOutput("arst_out_valid", {31'b0, out_valid_c}, 32'd0);
        checkOutput("arst_occ", {30'b0, occ_c}, 32'd0);
        checkOutput("arst_out_data", out_data_c, 32'd0);
        checkOutput("arst_hold_data", out_data_h, 32'd0);
        checkOutput("arst_in_ready", {31'b0, in_ready_c}, 32'd1);
        applyStimulus(0, 0, 0, 32'h0, 0);
        rst = 1'b0;
        tick();
        checkOutput("arst_after_occ", {30'b0, occ_c}, 32'd0);
        checkOutput("arst_after_valid", {31'b0, out_valid_c}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
